pipe_scroller: RTL and testbench

- Playfield stage directly downstream of the pipe-column generator.
- Captures each freshly generated 16-bit pipe column and scrolls the stored columns one position left per advance tick, forming the LED-matrix frame.
- Detects bird/pipe collision at a fixed bird column and counts pipes cleared.
- Feeds the display driver and the game-control FSM.

---
 rtl/pipe_scroller.sv | 75 +++++++
 tb/tb_pipe_scroller.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_scroller.sv
// Playfield stage: captures generated pipe columns, scrolls them left on each
// advance tick, detects bird/pipe collision and counts cleared pipes.
// Optional macro GROUND_HIT_EN: bird on row 0 also counts as a collision.
module pipe_scroller #(
  parameter int ROWS     = 16,
  parameter int COLS     = 16,
  parameter int BIRD_COL = 3,
  parameter int SCORE_W  = 8
) (
  input  logic                      Clock,
  input  logic                      RST,
  input  logic                      tick,
  input  logic                      run,
  input  logic [ROWS-1:0]           col_in,
  input  logic [$clog2(ROWS)-1:0]   bird_row,
  output logic [ROWS*COLS-1:0]      frame,
  output logic                      hit,
  output logic [SCORE_W-1:0]        score,
  output logic                      score_pulse
);

  logic [ROWS-1:0] col [COLS];
  logic [ROWS-1:0] pend;
  logic            pend_valid;
  logic            adv;
  logic            coll;
  logic            clear;

  assign adv = tick & run & ~hit;

  always_comb begin
    coll = 1'b0;
    if (int'(bird_row) < ROWS) coll = col[BIRD_COL][bird_row];
`ifdef GROUND_HIT_EN
    if (bird_row == '0) coll = 1'b1;
`else
`endif
  end

  // Trailing edge of a pipe leaving the bird column; never scores on a collision.
  assign clear = (col[BIRD_COL] != '0) && (col[BIRD_COL+1] == '0) && !coll;

  always_comb begin
    frame = '0;
    for (int unsigned c = 0; c < COLS; c++) frame[c*ROWS +: ROWS] = col[c];
  end

  always_ff @(posedge Clock or posedge RST) begin
    if (RST) begin
      for (int unsigned c = 0; c < COLS; c++) col[c] <= '0;
      pend        <= '0;
      pend_valid  <= 1'b0;
      hit         <= 1'b0;
      score       <= '0;
      score_pulse <= 1'b0;
    end else begin
      if (adv) begin
        for (int unsigned c = 0; c < COLS - 1; c++) col[c] <= col[c+1];
        if (col_in != '0)    col[COLS-1] <= col_in;
        else if (pend_valid) col[COLS-1] <= pend;
        else                 col[COLS-1] <= '0;
      end

      // Capture continues while frozen; any advance consumes the pending slot.
      if (col_in != '0) pend <= col_in;
      if (adv)                pend_valid <= 1'b0;
      else if (col_in != '0)  pend_valid <= 1'b1;

      hit         <= hit | coll;
      score_pulse <= adv & clear;
      if (adv && clear && score != '1) score <= score + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_scroller.sv
// Directed bench for pipe_scroller: vector table for bypass/overwrite/freeze,
// hand sequences for reset, pass-through, collision, saturation and ground hit.
module tb_pipe_scroller;
  localparam int ROWS = 16;
  localparam int COLS = 16;

  logic                 Clock = 1'b0;
  logic                 RST = 1'b0;
  logic                 tick = 1'b0;
  logic                 run = 1'b0;
  logic [ROWS-1:0]      col_in = '0;
  logic [3:0]           bird_row = 4'd7;
  logic [ROWS*COLS-1:0] frame, frame_s, saved;
  logic                 hit, hit_s, pulse, pulse_s;
  logic [7:0]           score;
  logic [1:0]           score_s;

  int checks = 0;
  int passed = 0;

  pipe_scroller #(.ROWS(16), .COLS(16), .BIRD_COL(3), .SCORE_W(8)) dut (
    .Clock(Clock), .RST(RST), .tick(tick), .run(run), .col_in(col_in),
    .bird_row(bird_row), .frame(frame), .hit(hit), .score(score),
    .score_pulse(pulse));

  pipe_scroller #(.ROWS(16), .COLS(16), .BIRD_COL(3), .SCORE_W(2)) dut_s (
    .Clock(Clock), .RST(RST), .tick(tick), .run(run), .col_in(col_in),
    .bird_row(bird_row), .frame(frame_s), .hit(hit_s), .score(score_s),
    .score_pulse(pulse_s));

  always #5 Clock = ~Clock;

  typedef struct {
    logic        t;
    logic        r;
    logic [15:0] cin;
    logic [15:0] e15;
    logic [15:0] e14;
    logic [7:0]  esc;
  } vec_t;

  vec_t vt [14];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic cyc(input logic t, input logic [15:0] c);
    tick = t;
    col_in = c;
    @(posedge Clock);
    #1;
    tick = 1'b0;
    col_in = '0;
  endtask

  function automatic logic [15:0] colv(input int c);
    return frame[c*ROWS +: ROWS];
  endfunction

  task automatic do_reset();
    #2 RST = 1'b1;
    #1;
    RST = 1'b0;
    @(posedge Clock);
    #1;
  endtask

  // Load F83F via pending buffer, then advance it to column 3 (13 ticks total).
  task automatic feed_to_col3();
    cyc(1'b0, 16'hF83F);
    cyc(1'b0, 16'h0000);
    cyc(1'b1, 16'h0000);
    chk("load_col15", {240'd0, colv(15)}, {240'd0, 16'hF83F});
    for (int i = 2; i <= 13; i++) begin
      cyc(1'b1, 16'h0000);
      cyc(1'b0, 16'h0000);
    end
  endtask

  initial begin
    int exp_s;
    logic exp_p;

    vt[0]  = '{1'b0, 1'b1, 16'h00FF, 16'h0000, 16'h0000, 8'd0};
    vt[1]  = '{1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 8'd0};
    vt[2]  = '{1'b0, 1'b1, 16'hFF00, 16'h0000, 16'h0000, 8'd0};
    vt[3]  = '{1'b1, 1'b1, 16'h0000, 16'hFF00, 16'h0000, 8'd0};
    vt[4]  = '{1'b0, 1'b1, 16'hFF00, 16'hFF00, 16'h0000, 8'd0};
    vt[5]  = '{1'b1, 1'b1, 16'h0F0F, 16'h0F0F, 16'hFF00, 8'd0};
    vt[6]  = '{1'b1, 1'b1, 16'h0000, 16'h0000, 16'h0F0F, 8'd0};
    vt[7]  = '{1'b0, 1'b1, 16'h00F0, 16'h0000, 16'h0F0F, 8'd0};
    for (int i = 8; i < 13; i++) vt[i] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0F0F, 8'd0};
    vt[13] = '{1'b1, 1'b1, 16'h0000, 16'h00F0, 16'h0000, 8'd0};

    // Asynchronous reset from power-up, checked before any clock edge.
    #2 RST = 1'b1;
    #1;
    chk("por_frame", frame, '0);
    chk("por_hit", {255'd0, hit}, '0);
    chk("por_score", {248'd0, score}, '0);
    chk("por_pulse", {255'd0, pulse}, '0);
    @(posedge Clock);
    #1 RST = 1'b0;
    @(posedge Clock);
    #1;

    // Pass-through: bird on row 7 clears the F83F gap.
    run = 1'b1;
    bird_row = 4'd7;
    feed_to_col3();
    chk("pass_col3", {240'd0, colv(3)}, {240'd0, 16'hF83F});
    chk("pass_hit", {255'd0, hit}, '0);
    chk("pass_score0", {248'd0, score}, '0);
    cyc(1'b1, 16'h0000);
    chk("pass_col2", {240'd0, colv(2)}, {240'd0, 16'hF83F});
    chk("pass_score1", {248'd0, score}, {248'd0, 8'd1});
    chk("pass_pulse", {255'd0, pulse}, {255'd0, 1'b1});
    cyc(1'b0, 16'h0000);
    chk("pass_pulse_off", {255'd0, pulse}, '0);

    // Async reset mid-run with non-zero frame and score.
    cyc(1'b0, 16'h0000);
    #2 RST = 1'b1;
    #1;
    chk("rst_frame", frame, '0);
    chk("rst_score", {248'd0, score}, '0);
    chk("rst_hit", {255'd0, hit}, '0);
    #1 RST = 1'b0;
    @(posedge Clock);
    #1;

    // Collision: bird on row 2 meets lit pixel.
    bird_row = 4'd2;
    feed_to_col3();
    do_reset();
    bird_row = 4'd2;
    cyc(1'b0, 16'hF83F);
    cyc(1'b0, 16'h0000);
    for (int i = 1; i <= 13; i++) cyc(1'b1, 16'h0000);
    chk("coll_hit_lat", {255'd0, hit}, '0);
    cyc(1'b0, 16'h0000);
    chk("coll_hit", {255'd0, hit}, {255'd0, 1'b1});
    saved = frame;
    for (int i = 0; i < 3; i++) cyc(1'b1, 16'h0000);
    chk("coll_frozen", frame, saved);
    chk("coll_score", {248'd0, score}, '0);
    chk("coll_sticky", {255'd0, hit}, {255'd0, 1'b1});
    do_reset();
    chk("coll_cleared", {255'd0, hit}, '0);

    // Vector table: bypass, overwrite, freeze with pending capture.
    bird_row = 4'd7;
    for (int i = 0; i < 14; i++) begin
      run = vt[i].r;
      cyc(vt[i].t, vt[i].cin);
      chk($sformatf("vec%0d_c15", i), {240'd0, colv(15)}, {240'd0, vt[i].e15});
      chk($sformatf("vec%0d_c14", i), {240'd0, colv(14)}, {240'd0, vt[i].e14});
      chk($sformatf("vec%0d_score", i), {248'd0, score}, {248'd0, vt[i].esc});
    end
    run = 1'b1;

    // Saturation on the 2-bit score instance: pipes at ticks 1,3,5,7 score on 14,16,18,20.
    do_reset();
    exp_s = 0;
    for (int n = 1; n <= 20; n++) begin
      cyc(1'b1, (n % 2 == 1 && n <= 7) ? 16'hF83F : 16'h0000);
      exp_p = (n >= 14) && (n % 2 == 0);
      if (exp_p && exp_s < 3) exp_s++;
      chk($sformatf("sat%0d_score", n), {254'd0, score_s}, 256'(exp_s));
      chk($sformatf("sat%0d_pulse", n), {255'd0, pulse_s}, {255'd0, exp_p});
    end

    // Ground row on an empty frame.
    do_reset();
    bird_row = 4'd0;
    cyc(1'b0, 16'h0000);
    cyc(1'b0, 16'h0000);
`ifdef GROUND_HIT_EN
    chk("ground_hit", {255'd0, hit}, {255'd0, 1'b1});
`else
    chk("ground_hit", {255'd0, hit}, '0);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
